// File: rtl/jtpang_objdma.sv
// jtpang_objdma -- object DMA controller feeding the sprite renderer.
//
// On a CPU trigger the block takes the Z80 bus (BUSRQ/BUSAK), walks the
// 2^AW-byte object attribute table through the shared VRAM read port and
// copies it into the renderer's object buffer. When the copy finishes it
// releases the bus and pulses done.
//
// Build option: JTPANG_OBJDMA_DBLBUF_EN
//   defined   : the object buffer is double-banked. Writes go to ~rd_bank
//               and the banks swap on the VS rising edge that follows a
//               completed copy.
//   undefined : single bank. buf_addr MSB and rd_bank are tied to 0.
//
// Parameters:
//   AW       object-table address width (table is 2^AW bytes)
//   WAIT_VB  1: hold a pending request until LVBL is low; 0: request at once
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   cen         transfer clock enable; one byte moves per enabled cycle
//   LVBL, VS    vertical blank (active low), vertical sync
//   dma_go      single-clk CPU trigger
//   busak_n     Z80 bus acknowledge (active low)
//   busrq       Z80 bus request (active high)
//   dma_addr    attribute RAM read address
//   dma_din     attribute RAM read data, valid one cen after dma_addr
//   buf_we      object buffer write strobe (one clk)
//   buf_addr    object buffer write address, MSB = bank
//   buf_din     object buffer write data
//   rd_bank     bank the renderer reads
//   busy        high from accepted request until the bus is released
//   done        single-clk pulse when the copy ends (normally or aborted)
module jtpang_objdma #(
   parameter int AW      = 9,
   parameter int WAIT_VB = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          LVBL,
   input  logic          VS,
   input  logic          dma_go,
   input  logic          busak_n,
   output logic          busrq,
   output logic [AW-1:0] dma_addr,
   input  logic [7:0]    dma_din,
   output logic          buf_we,
   output logic [AW:0]   buf_addr,
   output logic [7:0]    buf_din,
   output logic          rd_bank,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_XFER,
      ST_DONE
   } state_t;

   state_t        state, state_nx;
   logic          pending;
   logic          ak_seen;     // busak_n was low on the previous cen in REQ
   logic          first_p0;    // first XFER cen: read issued, nothing to write yet
   logic          last_p0;     // read address has wrapped: next cen is the last write
   logic [AW-1:0] addr_p1;     // address whose data arrives on the next cen
   logic          wr_bank;

   logic          start, grant, step, fin, abort, rel;

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      grant    = 1'b0;
      step     = 1'b0;
      fin      = 1'b0;
      abort    = 1'b0;
      rel      = 1'b0;
      if (cen) begin
         case (state)
            ST_IDLE: begin
               if (pending && (WAIT_VB == 0 || !LVBL)) begin
                  state_nx = ST_REQ;
                  start    = 1'b1;
               end
            end
            ST_REQ: begin
               if (!busak_n && ak_seen) begin
                  state_nx = ST_XFER;
                  grant    = 1'b1;
               end
            end
            ST_XFER: begin
               // Losing the bus mid-copy is illegal; end the copy without
               // marking the table as fresh.
               if (busak_n) begin
                  abort    = 1'b1;
                  state_nx = ST_DONE;
               end else begin
                  step = 1'b1;
                  if (last_p0) begin
                     fin      = 1'b1;
                     state_nx = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (busak_n) begin
                  rel      = 1'b1;
                  state_nx = ST_IDLE;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         pending  <= 1'b0;
         ak_seen  <= 1'b0;
         busrq    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         first_p0 <= 1'b0;
         last_p0  <= 1'b0;
         dma_addr <= '0;
         addr_p1  <= '0;
         buf_we   <= 1'b0;
         buf_addr <= '0;
         buf_din  <= '0;
      end else begin
         state  <= state_nx;
         done   <= fin | abort;
         buf_we <= step & ~first_p0;

         // A trigger during a copy is remembered and served afterwards;
         // a new trigger wins over the clear so none is lost.
         if (dma_go)
            pending <= 1'b1;
         else if (start)
            pending <= 1'b0;

         if (start) begin
            busrq <= 1'b1;
            busy  <= 1'b1;
         end
         if (fin | abort)
            busrq <= 1'b0;
         if (rel)
            busy <= 1'b0;

         if (cen)
            ak_seen <= (state == ST_REQ) && !busak_n;

         // stage 0: read address
         if (grant) begin
            dma_addr <= '0;
            first_p0 <= 1'b1;
            last_p0  <= 1'b0;
         end
         if (step) begin
            addr_p1  <= dma_addr;
            first_p0 <= 1'b0;
            if (!last_p0) begin
               dma_addr <= dma_addr + AW'(1);
               if (dma_addr == '1)
                  last_p0 <= 1'b1;
            end
            // stage 1: data returned for addr_p1 is written
            if (!first_p0) begin
               buf_din  <= dma_din;
               buf_addr <= {wr_bank, addr_p1};
            end
         end
      end
   end

`ifdef JTPANG_OBJDMA_DBLBUF_EN
   logic vs_l;
   logic swap_pending;

   // Swap only on a VS edge after a complete copy, and never while a
   // copy is filling the back bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_l         <= 1'b0;
         swap_pending <= 1'b0;
         rd_bank      <= 1'b0;
      end else begin
         vs_l <= VS;
         if (fin)
            swap_pending <= 1'b1;
         else if (VS && !vs_l && swap_pending && state != ST_XFER) begin
            rd_bank      <= ~rd_bank;
            swap_pending <= 1'b0;
         end
      end
   end

   assign wr_bank = ~rd_bank;
`else
   logic unused_vs;

   assign unused_vs = VS;
   assign rd_bank   = 1'b0;
   assign wr_bank   = 1'b0;
`endif

endmodule

// File: tb/tb_jtpang_objdma.sv
// Testbench for jtpang_objdma: scoreboard of expected buffer writes,
// pushed when a trigger is issued and popped on every buf_we.
module tb_jtpang_objdma;

`ifdef JTPANG_OBJDMA_DBLBUF_EN
   localparam bit DBL = 1'b1;
`else
   localparam bit DBL = 1'b0;
`endif

   typedef struct packed {
      logic [9:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       cen     = 1'b0;
   logic       LVBL    = 1'b0;
   logic       VS      = 1'b0;
   logic       dma_go  = 1'b0;
   logic       busak_n = 1'b1;
   logic       busrq;
   logic [8:0] dma_addr;
   logic [7:0] dma_din = 8'h00;
   logic       buf_we;
   logic [9:0] buf_addr;
   logic [7:0] buf_din;
   logic       rd_bank;
   logic       busy;
   logic       done;

   // second instance: WAIT_VB=0, small table, bus never granted
   logic       go2      = 1'b0;
   logic       busak2_n = 1'b1;
   logic [7:0] din2     = 8'h00;
   logic       busrq2;
   logic [3:0] unused_addr2;
   logic       unused_we2;
   logic [4:0] unused_baddr2;
   logic [7:0] unused_bdin2;
   logic       unused_rdb2;
   logic       busy2;
   logic       unused_done2;

   int  n_chk = 0, n_pass = 0;
   int  cen_cnt = 0, nwr = 0, ndone = 0, done_cen = 0, go_cen = 0;
   int  ack_dly = 0, ak_cnt = 0;
   bit  force_hi = 1'b0, sb_en = 1'b1;
   bit  exp_rd = 1'b0;
   wr_t sb_q[$];

   jtpang_objdma #(.AW(9), .WAIT_VB(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .VS(VS),
      .dma_go(dma_go), .busak_n(busak_n), .busrq(busrq),
      .dma_addr(dma_addr), .dma_din(dma_din), .buf_we(buf_we),
      .buf_addr(buf_addr), .buf_din(buf_din), .rd_bank(rd_bank),
      .busy(busy), .done(done)
   );

   jtpang_objdma #(.AW(4), .WAIT_VB(0)) u_nw (
      .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .VS(VS),
      .dma_go(go2), .busak_n(busak2_n), .busrq(busrq2),
      .dma_addr(unused_addr2), .dma_din(din2), .buf_we(unused_we2),
      .buf_addr(unused_baddr2), .buf_din(unused_bdin2), .rd_bank(unused_rdb2),
      .busy(busy2), .done(unused_done2)
   );

   always #5 clk = ~clk;

   // cen every other clk
   always @(negedge clk) cen = ~cen;

   always @(posedge clk) if (cen) cen_cnt <= cen_cnt + 1;

   // attribute RAM: synchronous read, pattern addr ^ 0x5A
   always @(posedge clk) if (cen) dma_din <= dma_addr[7:0] ^ 8'h5A;

   // Z80 bus model: acknowledge ack_dly clks after busrq, release on drop
   always @(negedge clk) begin
      if (force_hi || !busrq) begin
         busak_n = 1'b1;
         ak_cnt  = 0;
      end else begin
         if (ak_cnt >= ack_dly) busak_n = 1'b0;
         ak_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   // write monitor / scoreboard consumer
   always @(negedge clk) begin
      if (rst_n) begin
         if (buf_we) begin
            nwr++;
            if (sb_en) begin
               if (sb_q.size() == 0)
                  chk("sb_extra_wr", {22'b0, buf_addr}, 32'hFFFF_FFFF);
               else begin
                  wr_t e;
                  e = sb_q.pop_front();
                  chk("wr_addr", {22'b0, buf_addr}, {22'b0, e.addr});
                  chk("wr_data", {24'b0, buf_din}, {24'b0, e.data});
               end
            end
         end
         if (done) begin
            ndone++;
            done_cen = cen_cnt;
         end
      end
   end

   task automatic push_xfer(input bit bank);
      for (int i = 0; i < 512; i++) begin
         wr_t e;
         logic [8:0] a;
         a = 9'(i);
         e.addr = {bank, a};
         e.data = a[7:0] ^ 8'h5A;
         sb_q.push_back(e);
      end
   endtask

   task automatic pulse_go();
      @(negedge clk) dma_go = 1'b1;
      @(negedge clk) dma_go = 1'b0;
      go_cen = cen_cnt;
   endtask

   task automatic wait_done(input int tgt, input int bound);
      int t = 0;
      while (ndone < tgt && t < bound) begin
         @(negedge clk);
         t++;
      end
      chk("done_timeout", {31'b0, ndone >= tgt}, 32'd1);
   endtask

   task automatic wait_idle(input int bound);
      int t = 0;
      while (busy && t < bound) begin
         @(negedge clk);
         t++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic wait_addr(input logic [8:0] a, input int bound);
      int t = 0;
      while (dma_addr != a && t < bound) begin
         @(negedge clk);
         t++;
      end
      chk("addr_timeout", {23'b0, dma_addr}, {23'b0, a});
   endtask

   task automatic vs_pulse();
      @(negedge clk) VS = 1'b1;
      repeat (3) @(negedge clk);
      if (DBL) exp_rd = ~exp_rd;
      chk("rd_bank_vs", {31'b0, rd_bank}, {31'b0, exp_rd});
      VS = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int nd0, nw0, drops, t;

      // reset values
      repeat (4) @(negedge clk);
      chk("rst_busrq", {31'b0, busrq}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_we", {31'b0, buf_we}, 32'd0);
      chk("rst_dma_addr", {23'b0, dma_addr}, 32'd0);
      chk("rst_buf_addr", {22'b0, buf_addr}, 32'd0);
      chk("rst_buf_din", {24'b0, buf_din}, 32'd0);
      chk("rst_rd_bank", {31'b0, rd_bank}, 32'd0);
      chk("rst_busrq2", {31'b0, busrq2}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // WAIT_VB=0 instance requests at once even outside vblank
      LVBL = 1'b1;
      @(negedge clk) go2 = 1'b1;
      @(negedge clk) go2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("nw_busrq", {31'b0, busrq2}, 32'd1);
      chk("nw_busy", {31'b0, busy2}, 32'd1);

      // WAIT_VB=1: held until LVBL falls
      push_xfer(~exp_rd & DBL);
      pulse_go();
      repeat (20) @(negedge clk);
      chk("vb_hold_busrq", {31'b0, busrq}, 32'd0);
      chk("vb_hold_busy", {31'b0, busy}, 32'd0);
      LVBL = 1'b0;
      repeat (2) @(negedge clk);
      chk("vb_busrq", {31'b0, busrq}, 32'd1);
      wait_done(1, 3000);
      wait_idle(50);
      chk("b_q_empty", sb_q.size(), 32'd0);
      chk("b_writes", nwr, 32'd512);
      chk("rd_bank_before_vs", {31'b0, rd_bank}, 32'd0);
      vs_pulse();

      // latency with immediate acknowledge; second bank
      nd0 = ndone;
      push_xfer(~exp_rd & DBL);
      pulse_go();
      wait_done(nd0 + 1, 3000);
      wait_idle(50);
      chk("latency", done_cen - go_cen, 32'd516);
      chk("c_q_empty", sb_q.size(), 32'd0);

      // acknowledge 3 cen late: busrq must stay up until the copy ends
      ack_dly = 6;
      nd0 = ndone;
      push_xfer(~exp_rd & DBL);
      pulse_go();
      drops = 0;
      t = 0;
      while (!busrq && t < 20) begin @(negedge clk); t++; end
      chk("d_busrq_up", {31'b0, busrq}, 32'd1);
      t = 0;
      while (!done && t < 3000) begin
         @(negedge clk);
         t++;
         if (!busrq && !done) drops++;
      end
      chk("d_busrq_held", drops, 32'd0);
      wait_done(nd0 + 1, 10);
      wait_idle(50);
      chk("d_q_empty", sb_q.size(), 32'd0);
      ack_dly = 0;

      // two triggers during one busy period -> exactly two copies
      nd0 = ndone;
      push_xfer(~exp_rd & DBL);
      push_xfer(~exp_rd & DBL);
      pulse_go();
      repeat (9) @(negedge clk);
      chk("e_busy_at_2nd", {31'b0, busy}, 32'd1);
      pulse_go();
      wait_done(nd0 + 2, 6000);
      wait_idle(50);
      repeat (1200) @(negedge clk);
      chk("e_two_done", ndone - nd0, 32'd2);
      chk("e_q_empty", sb_q.size(), 32'd0);
      chk("e_idle", {31'b0, busy}, 32'd0);
      vs_pulse();

      // bus stolen back mid-copy: abort without a swap
      sb_en = 1'b0;
      nd0 = ndone;
      nw0 = nwr;
      pulse_go();
      wait_addr(9'h100, 3000);
      force_hi = 1'b1;
      wait_done(nd0 + 1, 50);
      wait_idle(50);
      chk("f_busrq", {31'b0, busrq}, 32'd0);
      chk("f_partial", {31'b0, (nwr - nw0) < 512}, 32'd1);
      force_hi = 1'b0;
      @(negedge clk) VS = 1'b1;
      repeat (3) @(negedge clk);
      chk("f_rd_bank_kept", {31'b0, rd_bank}, {31'b0, exp_rd});
      VS = 1'b0;
      repeat (4) @(negedge clk);

      // asynchronous reset mid-copy
      nd0 = ndone;
      pulse_go();
      wait_addr(9'h080, 3000);
      #1 rst_n = 1'b0;
      #1;
      chk("g_busrq", {31'b0, busrq}, 32'd0);
      chk("g_busy", {31'b0, busy}, 32'd0);
      chk("g_we", {31'b0, buf_we}, 32'd0);
      chk("g_dma_addr", {23'b0, dma_addr}, 32'd0);
      exp_rd = 1'b0;
      nw0 = nwr;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("g_no_writes", nwr - nw0, 32'd0);
      chk("g_no_done", ndone - nd0, 32'd0);
      chk("g_busrq_after", {31'b0, busrq}, 32'd0);
      chk("g_rd_bank", {31'b0, rd_bank}, {31'b0, exp_rd});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
